// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 5-stage RV32I core.
// Owns the PC, drives a ready/valid instruction-memory port and fills the
// IF/ID register. A one-entry skid buffer absorbs the fetch that completes
// while decode is stalled. An EX-resolved redirect flushes IF/ID. If a fetch
// is still in flight when the redirect arrives, that fetch is discarded.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect flag).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        fetch_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, BUF, DISCARD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic [31:0] tgt;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign tgt = align_pc(redirect_pc);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a redirect overrides stall in every state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH: begin
        if (redirect_valid)     state_nxt = im_ready ? FETCH : DISCARD;
        else if (im_ready)      state_nxt = stall ? BUF : FETCH;
      end
      BUF: begin
        if (redirect_valid || !stall) state_nxt = FETCH;
      end
      DISCARD: begin
        if (im_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-port outputs; the address is the PC, held while a request waits
  always_comb begin
    im_req  = (state == FETCH) || (state == DISCARD);
    im_addr = pc;
  end

  // PC and pending redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
    end else if (redirect_valid) begin
      case (state)
        FETCH: begin
          if (im_ready) pc      <= tgt;
          else          pend_pc <= tgt;
        end
        DISCARD: begin
          pend_pc <= tgt;
          if (im_ready) pc <= tgt;
        end
        default: pc <= tgt;
      endcase
    end else begin
      case (state)
        FETCH:   if (im_ready) pc <= pc + 32'd4;
        DISCARD: if (im_ready) pc <= pend_pc;
        default: ;
      endcase
    end
  end

  // Skid buffer captures a fetch that completes while decode is stalled
  always_ff @(posedge clk) begin
    if (state == FETCH && im_ready && stall && !redirect_valid) begin
      buf_pc   <= pc;
      buf_inst <= im_rdata;
    end
  end

  // IF/ID register: load, hold, or insert a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'h0;
      ifid_inst  <= NOP;
    end else if (redirect_valid || state == DISCARD) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= NOP;
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            if (im_ready) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= pc;
              ifid_inst  <= im_rdata;
            end else begin
              ifid_valid <= 1'b0;
              ifid_inst  <= NOP;
            end
          end
        end
        BUF: begin
          if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= buf_pc;
            ifid_inst  <= buf_inst;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky flag: any redirect target with nonzero low bits
  always_ff @(posedge clk) begin
    if (rst)                                       fetch_misalign <= 1'b0;
    else if (redirect_valid && |redirect_pc[1:0])  fetch_misalign <= 1'b1;
  end
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with a scoreboard
// of expected IF/ID entries, popped whenever a fresh valid entry appears.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        fetch_misalign;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  // Distinct, address-dependent instruction word
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_0000;
  endfunction

  assign im_rdata = inst_of(im_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ready       (im_ready),
    .im_rdata       (im_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_inst      (ifid_inst),
    .fetch_misalign (fetch_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; a fresh IF/ID entry appears only if stall was low at the edge
  task automatic step();
    logic s;
    logic [31:0] e;
    s = stall;
    @(posedge clk);
    #1;
    if (ifid_valid && !s && !rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_entry", ifid_pc, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", ifid_pc, e);
        chk("sb_inst", ifid_inst, inst_of(e));
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; im_ready = 1'b1;
    step(); step();
    chk("rst_im_req", {31'b0, im_req}, 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_inst", ifid_inst, 32'h0000_0013);
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

    // Zero-wait streaming
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step();
    chk("start_im_req", {31'b0, im_req}, 32'd1);
    chk("start_im_addr", im_addr, 32'd0);
    chk("start_valid", {31'b0, ifid_valid}, 32'd0);
    for (int i = 1; i <= 2; i++) begin
      step();
      chk("stream_addr", im_addr, 32'(4 * i));
      chk("stream_valid", {31'b0, ifid_valid}, 32'd1);
    end

    // Stall 3 cycles at pc 8 with memory ready
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_im_req", {31'b0, im_req}, 32'd0);
      chk("stall_hold_pc", ifid_pc, 32'h4);
      chk("stall_hold_valid", {31'b0, ifid_valid}, 32'd1);
    end
    stall = 1'b0;
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    step();
    chk("unstall_pc", ifid_pc, 32'h8);
    chk("unstall_addr", im_addr, 32'hC);
    step();
    chk("unstall_pc2", ifid_pc, 32'hC);
    chk("unstall_addr2", im_addr, 32'h10);

    // Redirect to 0x20 while memory is ready
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    chk("redir_bubble", {31'b0, ifid_valid}, 32'd0);
    chk("redir_addr", im_addr, 32'h20);

    // Redirect to 0x100 while the fetch at 0x20 is still pending
    im_ready = 1'b0; redirect_pc = 32'h100;
    step();
    chk("disc_addr_hold", im_addr, 32'h20);
    chk("disc_req", {31'b0, im_req}, 32'd1);
    chk("disc_bubble", {31'b0, ifid_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("disc_addr_hold2", im_addr, 32'h20);
    chk("disc_bubble2", {31'b0, ifid_valid}, 32'd0);
    im_ready = 1'b1;
    step();
    chk("disc_drop_addr", im_addr, 32'h100);
    chk("disc_drop_bubble", {31'b0, ifid_valid}, 32'd0);
    exp_q.push_back(32'h100);
    step();
    chk("tgt_addr", im_addr, 32'h104);

    // Redirect together with stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    chk("rs_bubble", {31'b0, ifid_valid}, 32'd0);
    chk("rs_addr", im_addr, 32'h200);
    redirect_valid = 1'b0;
    step();
    chk("rs_buf_req", {31'b0, im_req}, 32'd0);
    stall = 1'b0;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    step();
    chk("rs_pc", ifid_pc, 32'h200);
    step();
    chk("rs_pc2", ifid_pc, 32'h204);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    redirect_valid = 1'b0;
    chk("mis_addr", im_addr, 32'h300);
    chk("mis_flag", {31'b0, fetch_misalign}, {31'b0, MIS_EXP});
    exp_q.push_back(32'h300);
    step();
    chk("mis_sticky", {31'b0, fetch_misalign}, {31'b0, MIS_EXP});

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", im_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    step();
    chk("wrap_addr2", im_addr, 32'h0);
    step();
    chk("wrap_addr3", im_addr, 32'h4);

    // Reset while holding a buffered instruction
    stall = 1'b1;
    step();
    chk("pre_rst_req", {31'b0, im_req}, 32'd0);
    rst = 1'b1;
    step();
    chk("midrst_req", {31'b0, im_req}, 32'd0);
    chk("midrst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("midrst_inst", ifid_inst, 32'h0000_0013);
    chk("midrst_addr", im_addr, 32'h0);
    chk("midrst_misalign", {31'b0, fetch_misalign}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    exp_q.push_back(32'h0);
    step();
    chk("restart_req", {31'b0, im_req}, 32'd1);
    chk("restart_addr", im_addr, 32'h0);
    step();
    chk("restart_addr2", im_addr, 32'h4);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
